// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the divider state encoding.
package rv32_pkg;

  // Major opcodes used by the core's control FSM.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {IDLE, CALC, SIGN, SPECIAL, DONE} div_state_t;

  // True for the R-type M-extension encodings that go to the divider.
  function automatic logic is_div_op(input logic [6:0] opcode, input logic [6:0] func7,
                                     input logic [2:0] func3);
    return (opcode == OP_RTYPE) && (func7 == F7_MULDIV) && func3[2];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and shift in the quotient bit.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  // Partial remainder is one bit wider so the trial subtract's borrow lands in the MSB.
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_fits;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign w_fits  = ~w_diff[XLEN];

  // Restore (keep shifted value) when the divisor does not fit.
  always_comb begin
    o_rem = w_shift[XLEN-1:0];
    o_quo = {i_quo[XLEN-2:0], w_fits};
    if (w_fits) begin
      o_rem = w_diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative DIV/DIVU/REM/REMU unit: one quotient bit per cycle on operand
// magnitudes, sign fix-up afterwards, RISC-V results for the special cases.
module iter_divider
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      r_state;
  div_state_t      w_state_d;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CntW-1:0] r_cnt;
  logic            r_rem_sel;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  logic            w_signed_in;
  logic            w_accept;
  logic            w_special;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_special_res;

  assign w_signed_in = ~i_func3[0];
  assign w_accept    = i_start & i_func3[2] & ((r_state == IDLE) | (r_state == DONE));
  assign w_special   = (i_op2 == '0) |
                       (w_signed_in & (i_op1 == MinNeg) & (i_op2 == '1));
  // Magnitude of 0x8000_0000 wraps to itself, which is correct read as unsigned.
  assign w_abs1      = (w_signed_in & i_op1[XLEN-1]) ? -i_op1 : i_op1;
  assign w_abs2      = (w_signed_in & i_op2[XLEN-1]) ? -i_op2 : i_op2;

  assign w_quo_fix   = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix   = r_neg_r ? -r_rem : r_rem;
  // A zero latched divisor means divide-by-zero; otherwise it is the signed overflow case.
  assign w_special_res = (r_dvs == '0) ? (r_rem_sel ? r_op1 : '1)
                                       : (r_rem_sel ? '0 : MinNeg);

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_dvs),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  // State register and datapath: latch on accept, iterate in CALC, write result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_op1     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_op1     <= i_op1;
            r_quo     <= w_abs1;
            r_dvs     <= w_abs2;
            r_rem     <= '0;
            r_cnt     <= CntW'(XLEN - 1);
            r_rem_sel <= i_func3[1];
            r_neg_q   <= w_signed_in & (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
            r_neg_r   <= w_signed_in & i_op1[XLEN-1];
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
        end
        SIGN:    r_result <= r_rem_sel ? w_rem_fix : w_quo_fix;
        SPECIAL: r_result <= w_special_res;
        default: ;
      endcase
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_d = r_state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_d = w_special ? SPECIAL : CALC;
      end
      CALC: begin
        o_busy = 1'b1;
        if (r_cnt == '0) w_state_d = SIGN;
      end
      SIGN: begin
        o_busy    = 1'b1;
        w_state_d = DONE;
      end
      SPECIAL: begin
        o_busy    = 1'b1;
        w_state_d = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        w_state_d = IDLE;
        if (w_accept) w_state_d = w_special ? SPECIAL : CALC;
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected result and
// timing, a monitor checks busy every cycle and result/timing on each done.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          t0;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  iter_divider #(
    .XLEN (32)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_func3  (func3),
    .i_op1    (op1),
    .i_op2    (op2),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : a;
    case (f3)
      3'b100:  return sa / sb;
      3'b101:  return a / b;
      3'b110:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge: presents a request for one cycle and records its expectation.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start = 1'b1;
    func3 = f3;
    op1   = a;
    op2   = b;
    e.res      = model(f3, a, b);
    e.t0       = cyc + 1;
    e.done_cyc = e.t0 + (is_special(f3, a, b) ? 1 : 33);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle, so a following issue is back-to-back.
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wait_done: got %0d pending expected 0 pending", q.size());
      q.delete();
    end
  endtask

  // Monitor: busy against the scoreboard head every cycle, result and timing on done.
  always begin
    exp_t e;
    logic exp_busy;
    @(posedge clk);
    cyc++;
    #1;
    exp_busy = (q.size() > 0) && (cyc >= q[0].t0) && (cyc < q[0].done_cyc);
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_spurious: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.done_cyc);
      end
    end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
      checks++;
      errors++;
      $display("FAIL done_missing: got done=%b expected done=1 (cycle %0d)", done, cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    rst   = 1'b1;
    start = 1'b0;
    func3 = 3'b000;
    op1   = '0;
    op2   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Signed divide and remainder with mixed signs, idle issue.
    issue(3'b100, 32'd20, -32'sd3);
    wait_done();
    repeat (2) @(negedge clk);
    issue(3'b110, 32'd20, -32'sd3);
    wait_done();
    repeat (2) @(negedge clk);

    // Unsigned with a full-scale dividend.
    issue(3'b101, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    issue(3'b111, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    repeat (2) @(negedge clk);

    // Special cases: divide by zero and signed overflow.
    issue(3'b100, 32'd7, 32'd0);
    wait_done();
    issue(3'b111, 32'd7, 32'd0);
    wait_done();
    issue(3'b110, 32'hFFFF_FFF9, 32'd0);
    wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    repeat (2) @(negedge clk);

    // Re-pulsed start while busy must be ignored.
    issue(3'b100, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    func3 = 3'b111;
    op1   = 32'd55;
    op2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);

    // func3[2]=0 never starts the unit; the monitor flags any busy or done.
    start = 1'b1;
    func3 = 3'b000;
    op1   = 32'd9;
    op2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Synchronous reset mid-divide abandons it.
    issue(3'b100, 32'd123456, 32'd789);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    issue(3'b100, -32'sd7, 32'd2);
    wait_done();
    repeat (2) @(negedge clk);
    issue(3'b110, -32'sd7, 32'd2);
    wait_done();

    // Back-to-back issue in the done cycle.
    issue(3'b111, 32'd100, 32'd7);
    wait_done();
    repeat (2) @(negedge clk);

    // Random ops, mostly back-to-back, excluding the special cases.
    for (int i = 0; i < 1000; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) b = -b;
      if (is_special(f3, a, b)) b = 32'd5;
      issue(f3, a, b);
      wait_done();
      if ($urandom_range(0, 9) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
